// File: rtl/muldiv_sequencer_if.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer_if
// Handshake and data bundle between the EX-stage ALU controller and the
// iterative multiply/divide unit.
//   master : ALU controller side (drives Start/Op/A/B and the mthi/mtlo strobes)
//   slave  : muldiv_sequencer side (returns HI/LO, Busy, Done)
// Signals:
//   Start  - one-cycle request for a new operation
//   Op     - 00 mult, 01 multu, 10 div, 11 divu
//   A, B   - rs / rt operands
//   WrHi   - mthi strobe, WrLo - mtlo strobe, WrData - mthi/mtlo data
//   HI, LO - architectural result registers
//   Busy   - operation in flight, pipeline stalls HI/LO access
//   Done   - one-cycle pulse after HI/LO take the new result
// ---------------------------------------------------------------------------
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             WrHi;
   logic             WrLo;
   logic [WIDTH-1:0] WrData;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;
   logic             Busy;
   logic             Done;

   modport master (
      output Start, Op, A, B, WrHi, WrLo, WrData,
      input  HI, LO, Busy, Done
   );

   modport slave (
      input  Start, Op, A, B, WrHi, WrLo, WrData,
      output HI, LO, Busy, Done
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Serves mult, multu, div, divu (34 cycles: accept, WIDTH iterations, sign
// fix) and mthi/mtlo (single-edge writes while idle).
// Ports:
//   Clk   - single clock, rising edge
//   Rst_n - asynchronous active-low reset
//   bus   - muldiv_sequencer_if.slave (Start/Op/A/B/WrHi/WrLo/WrData in,
//           HI/LO/Busy/Done out, all outputs registered)
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting; accepts Start or mthi/mtlo writes
// RUN   | one multiplier bit / quotient bit per cycle on magnitudes
// FIX   | applies signs (or divide-by-zero result) and loads HI/LO
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic              Clk,
   input  logic              Rst_n,
   muldiv_sequencer_if.slave bus
);

   localparam int            CW        = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic               sa_q, sa_d;
   logic               sb_q, sb_d;
   logic [WIDTH-1:0]   a_mag_q, a_mag_d;
   logic [WIDTH-1:0]   b_mag_q, b_mag_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // operand signs only matter for the signed ops (Op[0] == 0)
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs;

   assign a_neg = bus.A[WIDTH-1] & ~bus.Op[0];
   assign b_neg = bus.B[WIDTH-1] & ~bus.Op[0];
   assign a_abs = a_neg ? -bus.A : bus.A;
   assign b_abs = b_neg ? -bus.B : bus.B;

   // Multiply step: acc holds {partial product, remaining multiplier bits}.
   // The upper half plus |A| needs one carry bit, which shifts back in.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & a_mag_q};
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide step: acc holds {remainder, dividend bits / quotient bits}.
   // The remainder stays below |B|, so the shifted value fits in WIDTH+1 bits
   // and a successful trial difference fits back into WIDTH bits.
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_diff;
   logic [2*WIDTH-1:0] div_next;

   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, b_mag_q};
   assign div_diff  = div_shift[WIDTH-1:0] - b_mag_q;
   assign div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

   // Sign fix. sa/sb are zero for unsigned ops, so no op check is needed here.
   logic               neg_res;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, a_orig;

   assign neg_res  = sa_q ^ sb_q;
   assign prod_fix = neg_res ? -acc_q : acc_q;
   assign quo_fix  = neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   // original dividend rebuilt from its latched magnitude and sign
   assign a_orig   = sa_q ? -a_mag_q : a_mag_q;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         a_mag_q <= '0;
         b_mag_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         a_mag_q <= a_mag_d;
         b_mag_q <= b_mag_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      a_mag_d = a_mag_q;
      b_mag_d = b_mag_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               // Start wins over a same-edge mthi/mtlo
               op_d    = bus.Op;
               sa_d    = a_neg;
               sb_d    = b_neg;
               a_mag_d = a_abs;
               b_mag_d = b_abs;
               acc_d   = {{WIDTH{1'b0}}, (bus.Op[1] ? a_abs : b_abs)};
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end else begin
               if (bus.WrHi) hi_d = bus.WrData;
               if (bus.WrLo) lo_d = bus.WrData;
            end
         end

         S_RUN: begin
            acc_d = op_q[1] ? div_next : mul_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) state_d = S_FIX;
         end

         S_FIX: begin
            if (op_q[1]) begin
               if (b_mag_q == '0) begin
                  hi_d = a_orig;
                  lo_d = '1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;
   assign bus.Busy = busy_q;
   assign bus.Done = done_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

   logic Clk = 1'b0;
   logic Rst_n = 1'b0;

   always #5 Clk = ~Clk;

   muldiv_sequencer_if #(.WIDTH(32)) bus();

   muldiv_sequencer #(.WIDTH(32)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   always @(negedge Clk) if (bus.Done === 1'b1) done_cnt++;

   task automatic cycles(input int n);
      repeat (n) @(negedge Clk);
   endtask

   // Drive Start across one rising edge (E0); returns at the falling edge after E0.
   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.Start = 1'b1;
      bus.Op    = op;
      bus.A     = a;
      bus.B     = b;
      @(posedge Clk);
      @(negedge Clk);
      bus.Start = 1'b0;
   endtask

   // Called just after E0. Samples after E0 .. E0+32 and counts cycles in which
   // Busy was low, Done was high or HI/LO moved; returns just after E0+33.
   task automatic run_through(input logic [63:0] old, output int bad);
      bad = 0;
      for (int k = 0; k < 33; k++) begin
         if (bus.Busy !== 1'b1 || bus.Done !== 1'b0 || {bus.HI, bus.LO} !== old) bad++;
         cycles(1);
      end
   endtask

   task automatic test_reset();
      bus.Start = 1'b0; bus.Op = 2'b00; bus.A = '0; bus.B = '0;
      bus.WrHi = 1'b0; bus.WrLo = 1'b0; bus.WrData = '0;
      Rst_n = 1'b0;
      cycles(2);
      n_checks++;
      if (bus.HI !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected %h", bus.HI, 32'h0); end
      n_checks++;
      if (bus.LO !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected %h", bus.LO, 32'h0); end
      n_checks++;
      if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
      n_checks++;
      if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.Done); end
      Rst_n = 1'b1;
      cycles(1);
   endtask

   task automatic run_table(input string name, input vec_t v[], input int n);
      int bad;
      int d0;
      for (int i = 0; i < n; i++) begin
         d0 = done_cnt;
         start_op(v[i].op, v[i].a, v[i].b);
         run_through({bus.HI, bus.LO}, bad);
         n_checks++;
         if (bad !== 0) begin n_fail++; $display("FAIL %s_%0d_busy_hold: %0d bad cycles, expected 0", name, i, bad); end
         n_checks++;
         if ({bus.Busy, bus.Done} !== 2'b01) begin n_fail++; $display("FAIL %s_%0d_done_cycle: busy/done %b expected 01", name, i, {bus.Busy, bus.Done}); end
         n_checks++;
         if (bus.HI !== v[i].hi) begin n_fail++; $display("FAIL %s_%0d_hi: got %h expected %h", name, i, bus.HI, v[i].hi); end
         n_checks++;
         if (bus.LO !== v[i].lo) begin n_fail++; $display("FAIL %s_%0d_lo: got %h expected %h", name, i, bus.LO, v[i].lo); end
         cycles(1);
         n_checks++;
         if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL %s_%0d_done_pulses: got %0d expected 1", name, i, done_cnt - d0); end
      end
   endtask

   task automatic test_multiply();
      vec_t v[] = new[4];
      v[0] = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      v[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      v[2] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      v[3] = '{2'b00, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2};
      run_table("mul", v, 4);
   endtask

   task automatic test_divide();
      vec_t v[] = new[7];
      v[0] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      v[1] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
      v[2] = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
      v[3] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      v[4] = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
      v[5] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      v[6] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
      run_table("div", v, 7);
   endtask

   task automatic test_busy_ignore();
      int bad = 0;
      logic [63:0] old;
      old = {bus.HI, bus.LO};
      start_op(2'b11, 32'd100, 32'd7);
      for (int k = 0; k < 33; k++) begin
         if (bus.Busy !== 1'b1 || {bus.HI, bus.LO} !== old) bad++;
         if (k == 4) begin bus.Start = 1'b1; bus.Op = 2'b00; bus.A = 32'd3; bus.B = 32'd3; end
         if (k == 5) bus.Start = 1'b0;
         if (k == 9) begin bus.WrHi = 1'b1; bus.WrData = 32'h0000AAAA; end
         if (k == 10) bus.WrHi = 1'b0;
         cycles(1);
      end
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL busy_ignore_hold: %0d bad cycles, expected 0", bad); end
      n_checks++;
      if (bus.HI !== 32'd2) begin n_fail++; $display("FAIL busy_ignore_hi: got %h expected %h", bus.HI, 32'd2); end
      n_checks++;
      if (bus.LO !== 32'd14) begin n_fail++; $display("FAIL busy_ignore_lo: got %h expected %h", bus.LO, 32'd14); end
      n_checks++;
      if (bus.Done !== 1'b1) begin n_fail++; $display("FAIL busy_ignore_done: got %b expected 1", bus.Done); end
      cycles(1);
      n_checks++;
      if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_not_queued: busy %b expected 0", bus.Busy); end
   endtask

   task automatic test_write();
      int bad;
      bus.WrHi = 1'b1; bus.WrLo = 1'b1; bus.WrData = 32'h5A5A5A5A;
      cycles(1);
      bus.WrHi = 1'b0; bus.WrLo = 1'b0;
      n_checks++;
      if (bus.HI !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL write_hi: got %h expected %h", bus.HI, 32'h5A5A5A5A); end
      n_checks++;
      if (bus.LO !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL write_lo: got %h expected %h", bus.LO, 32'h5A5A5A5A); end
      bus.WrLo = 1'b1; bus.WrData = 32'h00001111;
      start_op(2'b01, 32'd2, 32'd3);
      bus.WrLo = 1'b0;
      n_checks++;
      if (bus.LO !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL start_wins_lo: got %h expected %h", bus.LO, 32'h5A5A5A5A); end
      run_through({32'h5A5A5A5A, 32'h5A5A5A5A}, bad);
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL start_wins_busy_hold: %0d bad cycles, expected 0", bad); end
      n_checks++;
      if ({bus.HI, bus.LO} !== {32'd0, 32'd6}) begin n_fail++; $display("FAIL start_wins_result: got %h expected %h", {bus.HI, bus.LO}, {32'd0, 32'd6}); end
      cycles(1);
   endtask

   task automatic test_back_to_back();
      int bad;
      start_op(2'b01, 32'h00010000, 32'h00010000);
      run_through({bus.HI, bus.LO}, bad);
      n_checks++;
      if ({bus.Done, bus.HI, bus.LO} !== {1'b1, 32'd1, 32'd0}) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", {bus.Done, bus.HI, bus.LO}, {1'b1, 32'd1, 32'd0}); end
      start_op(2'b11, 32'd1000, 32'd10);
      n_checks++;
      if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy %b expected 1", bus.Busy); end
      run_through({32'd1, 32'd0}, bad);
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL b2b_busy_hold: %0d bad cycles, expected 0", bad); end
      n_checks++;
      if ({bus.HI, bus.LO} !== {32'd0, 32'd100}) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", {bus.HI, bus.LO}, {32'd0, 32'd100}); end
      cycles(1);
   endtask

   task automatic test_async_reset();
      int bad;
      int d0;
      start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
      cycles(16);
      @(posedge Clk);
      #2 Rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.HI, bus.LO} !== 64'h0) begin n_fail++; $display("FAIL async_reset_hilo: got %h expected %h", {bus.HI, bus.LO}, 64'h0); end
      n_checks++;
      if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b expected 0", bus.Busy); end
      cycles(2);
      Rst_n = 1'b1;
      d0 = done_cnt;
      cycles(40);
      n_checks++;
      if (done_cnt !== d0) begin n_fail++; $display("FAIL async_reset_no_done: got %0d pulses expected 0", done_cnt - d0); end
      start_op(2'b00, 32'd6, 32'd7);
      run_through(64'h0, bad);
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL post_reset_busy_hold: %0d bad cycles, expected 0", bad); end
      n_checks++;
      if (bus.LO !== 32'd42) begin n_fail++; $display("FAIL post_reset_lo: got %h expected %h", bus.LO, 32'd42); end
      n_checks++;
      if (bus.HI !== 32'd0) begin n_fail++; $display("FAIL post_reset_hi: got %h expected %h", bus.HI, 32'd0); end
      cycles(1);
   endtask

   initial begin
      test_reset();
      test_multiply();
      test_divide();
      test_busy_ignore();
      test_write();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

- Iterative multiply/divide unit with architectural HI/LO registers, serving MIPS `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo`.
- Sits beside the main ALU in EX. The ALU controller decodes the R-type funct and issues a one-cycle `Start` with an operation code.
- The pipeline stalls on `Busy` and reads HI/LO directly for `mfhi`/`mflo`.
- One operation takes 34 cycles: 1 accept, 32 iterate, 1 sign-fix.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits.
- `Clk` in 1: single clock. All state updates on the rising edge.
- `Rst_n` in 1: asynchronous, active-low reset.
- `Start` in 1: request a new operation. Sampled only in IDLE.
- `Op` in 2: operation code. 00 = mult, 01 = multu, 10 = div, 11 = divu.
- `A` in WIDTH: rs operand (multiplicand or dividend).
- `B` in WIDTH: rt operand (multiplier or divisor).
- `WrHi` in 1: `mthi` write strobe.
- `WrLo` in 1: `mtlo` write strobe.
- `WrData` in WIDTH: data for `mthi`/`mtlo`.
- `HI` out WIDTH: HI register. Holds the product upper half or the remainder.
- `LO` out WIDTH: LO register. Holds the product lower half or the quotient.
- `Busy` out 1: high in RUN and FIX. Pipeline must stall any HI/LO access while it is high.
- `Done` out 1: one-cycle pulse in the cycle after HI/LO update.

## Operation
- States:
  - IDLE → RUN on `Start`.
  - RUN → FIX when the iteration counter reaches WIDTH-1 (after the 32nd iteration).
  - FIX → IDLE unconditionally.
- Accept edge (IDLE with `Start`=1):
  - Latch `Op`.
  - Latch the operand signs: sA = A[31], sB = B[31], but only for signed ops; otherwise 0.
  - Latch the magnitudes |A| and |B| (raw values for unsigned ops).
  - Clear the 6-bit counter and the partial accumulators.
- RUN, multiply: shift-add, one multiplier bit per cycle. Produces a 64-bit unsigned product in a 64-bit accumulator.
- RUN, divide: restoring division, one quotient bit per cycle. Uses a 33-bit trial subtraction of |B| from the shifted remainder.
- FIX edge, signed multiply: if sA^sB, the 64-bit product is two's-complement negated.
- FIX edge, signed divide:
  - Quotient is negated if sA^sB.
  - Remainder is negated if sA.
- FIX edge, register update: HI ← upper half or remainder; LO ← lower half or quotient.
- Divide by zero (B = 0, any divide op):
  - Runs the full 34 cycles.
  - Result is fixed at HI = A (original operand as latched), LO = 32'hFFFFFFFF.
  - No sign fix is applied.
- Signed overflow case, div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (natural wrap, no trap).
- Arithmetic is modulo 2^WIDTH per register. The negation uses the full 64-bit width for the product.
- `mthi`/`mtlo`:
  - In IDLE, `WrHi`/`WrLo` write `WrData` to HI/LO on the edge. Both may be written on the same edge.
  - `Start` and a write on the same IDLE edge: `Start` wins and the write is dropped.
  - `WrHi`/`WrLo` are ignored while `Busy`.
- `Start` while `Busy`: ignored. It is not queued.
- Reset (asynchronous, any state): state = IDLE, HI = 0, LO = 0, `Busy` = 0, `Done` = 0, counter = 0. An in-flight operation is discarded.

## Timing
- Cycle numbering: accept edge E0.
  - `Busy` = 1 from after E0 through the cycle ending at E0+33.
  - RUN iterations occur on edges E0+1 … E0+32.
  - FIX occurs on E0+33.
- HI/LO hold their old values until E0+33. They show the new result immediately after E0+33.
- `Done` = 1 for exactly the cycle after E0+33. `Busy` = 0 in that same cycle.
- Back-to-back: a new `Start` can be accepted on edge E0+34, which is the edge that ends the `Done` cycle.
- `Busy` and `Done` are registered outputs (no combinational path from inputs). HI and LO are also registered.
- Reset values of all outputs: HI = 0, LO = 0, `Busy` = 0, `Done` = 0.

## Test plan
- mult A = 0xFFFFFFFD (−3), B = 5 → after 34 cycles HI = 0xFFFFFFFF, LO = 0xFFFFFFF1, with a single `Done` pulse in the cycle after E0+33.
- multu A = B = 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. Also: div A = 0xFFFFFFF9 (−7), B = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- divu A = 100, B = 7 → LO = 14, HI = 2. Then divu A = 0x1234, B = 0 → HI = 0x1234, LO = 0xFFFFFFFF.
- `Start` with different operands pulsed at E0+5, plus `WrHi` = 1 with `WrData` = 0xAAAA at E0+10 → both ignored. The result matches the first op and `Busy` stays 1 through E0+33.
- Same-edge `WrLo` and `Start` in IDLE: the operation starts and LO is not written. Separately, `WrHi` and `WrLo` together with `WrData` = 0x5A5A5A5A in IDLE → HI = LO = 0x5A5A5A5A on the next edge.
- Assert `Rst_n` = 0 asynchronously at E0+17 → HI = LO = 0 and `Busy` = 0 immediately, with no later `Done`. After release, a new mult 6 × 7 gives LO = 42, HI = 0.
